tb_sram_mp: RTL and testbench
=============================

TB_SRAM_MP -- requirements
Module: tb_sram_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, word width in bits; multiple of 8.
REQ-002 SHALL have parameter NUM_WORDS, default 32768, memory depth; power of two, elaboration error otherwise.
REQ-003 SHALL have parameter NUM_PORTS, default 2, independent request ports; 1..8.
REQ-004 SHALL have parameter READ_LATENCY, default 1, grant-to-rvalid cycles; 1..4, elaboration error otherwise.
REQ-005 SHALL have parameter STALL_SEED, default 16'hACE1, LFSR reset value; nonzero.
REQ-006 SHALL have port clk_i, input, 1, the single clock.
REQ-007 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-008 SHALL have port req_i, input, [NUM_PORTS], per-port request.
REQ-009 SHALL have port we_i, input, [NUM_PORTS], per-port write enable; 0 means read.
REQ-010 SHALL have port addr_i, input, [NUM_PORTS][$clog2(NUM_WORDS)], word address.
REQ-011 SHALL have port wdata_i, input, [NUM_PORTS][DATA_WIDTH], write data.
REQ-012 SHALL have port be_i, input, [NUM_PORTS][DATA_WIDTH/8], byte enables.
REQ-013 SHALL have port gnt_o, output, [NUM_PORTS], request accepted this cycle.
REQ-014 SHALL have port rvalid_o, output, [NUM_PORTS], response pulse.
REQ-015 SHALL have port rdata_o, output, [NUM_PORTS][DATA_WIDTH], read data, qualified by rvalid_o.

Function
REQ-016 SHALL perform at most one memory access per cycle; gnt_o SHALL be one-hot or zero.
REQ-017 SHALL grant by round-robin: search starts at pointer; after a grant to port k, pointer SHALL become (k+1) mod NUM_PORTS; pointer unchanged when no grant.
REQ-018 SHALL grant a lone requesting port every cycle when no stall is active.
REQ-019 SHALL, on a granted write, update only bytes with be_i set, visible to any read granted on the next cycle or later.
REQ-020 SHALL, on a granted read, assert rvalid_o[k] exactly READ_LATENCY cycles after the grant cycle, with rdata_o[k] holding the word as of the grant cycle.
REQ-021 SHALL, on a granted write, assert rvalid_o[k] READ_LATENCY cycles after grant with rdata_o[k] = 0.
REQ-022 SHALL hold rdata_o[k] = 0 whenever rvalid_o[k] = 0.
REQ-023 SHALL implement the response path as a READ_LATENCY-deep pipeline of {valid, port index, is_read}; one new entry per cycle, no back-pressure.
REQ-024 SHALL ignore be_i and wdata_i for reads; a write with be_i = 0 SHALL be granted and acknowledged without modifying memory.
REQ-025 SHALL rely on requesters holding req_i, we_i, addr_i, wdata_i, be_i stable until gnt_o; gnt_o is combinational from req_i.

Reset
REQ-026 SHALL, with rst_i high at a clock edge, clear all pipeline valids, set pointer to 0, load LFSR with STALL_SEED; gnt_o, rvalid_o, rdata_o SHALL be 0 during reset.
REQ-027 SHALL drop in-flight responses on reset mid-operation; writes granted before reset SHALL remain in memory.
REQ-028 SHALL NOT reset memory contents; initial contents X unless loaded by the bench via hierarchical access or $readmemh.

Configuration
REQ-029 SHALL, with TB_SRAM_MP_STALL_EN defined, advance a 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle and suppress all grants in cycles where LFSR[1:0] == 2'b00.
REQ-030 SHALL, without TB_SRAM_MP_STALL_EN, contain no LFSR; grants are never suppressed; STALL_SEED is unused.

Structure
REQ-031 SHALL place LFSR tap mask, MAX_PORTS = 8 and MAX_READ_LATENCY = 4 constants in package tb_sram_mp_pkg.
REQ-032 SHALL implement arbitration in sub-module tb_rr_arb (parameter N; req, enable, gnt one-hot, idx, pointer state).

Verification
REQ-033 Single port 0, write addr 5 data 64'hDEADBEEF_00000539 be 8'hFF, then read addr 5 -> gnt both same cycle as req; read rvalid READ_LATENCY cycles later, rdata 64'hDEADBEEF_00000539.
REQ-034 Write addr 7 = 64'h0, then write 64'hFFFFFFFF_FFFFFFFF be 8'h0F, read 7 -> rdata 64'h00000000_FFFFFFFF.
REQ-035 NUM_PORTS=3, all ports request reads continuously for 9 cycles -> grants to ports 0,1,2,0,1,2,0,1,2; each port sees 3 rvalids.
REQ-036 Port 0 writes addr 3 = 64'h1 granted cycle t; port 1 reads addr 3 granted t+1 -> port 1 rdata 64'h1.
REQ-037 Read granted, rst_i asserted before rvalid due -> no rvalid; after reset first grant goes to port 0.
REQ-038 With TB_SRAM_MP_STALL_EN, one port requesting for 1000 cycles -> grant count matches LFSR model (~750), every grant answered with rvalid after READ_LATENCY.

Source files
------------

// File: rtl/tb_sram_mp_pkg.sv
// Shared constants and types for the multi-port SRAM model.
package tb_sram_mp_pkg;

    localparam int unsigned MAX_PORTS        = 8;
    localparam int unsigned MAX_READ_LATENCY = 4;

    // Fibonacci taps 16,14,13,11 as bit positions 0,2,3,5 of a right-shifting register.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        logic       is_read;
    } rsp_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {^(state & LFSR_TAP_MASK), state[15:1]};
    endfunction

endpackage

// File: rtl/tb_rr_arb.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner.
module tb_rr_arb #(
    parameter int unsigned N    = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic            en_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % N);
            if (en_i && !valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (valid_o) begin
            ptr_d = (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tb_sram_mp.sv
// Multi-port single-access SRAM model with round-robin grant and fixed-latency responses.
// Define TB_SRAM_MP_STALL_EN to add LFSR-driven grant stalls.
module tb_sram_mp
    import tb_sram_mp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned NUM_WORDS    = 32768,
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [15:0] STALL_SEED   = 16'hACE1,
    localparam int unsigned AW = $clog2(NUM_WORDS),
    localparam int unsigned BW = DATA_WIDTH / 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_PORTS-1:0]                  req_i,
    input  logic [NUM_PORTS-1:0]                  we_i,
    input  logic [NUM_PORTS-1:0][AW-1:0]          addr_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_PORTS-1:0][BW-1:0]          be_i,
    output logic [NUM_PORTS-1:0]                  gnt_o,
    output logic [NUM_PORTS-1:0]                  rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o
);

    localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : g_err_dw
        $error("DATA_WIDTH must be a nonzero multiple of 8");
    end
    if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_err_words
        $error("NUM_WORDS must be a power of two");
    end
    if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS) begin : g_err_ports
        $error("NUM_PORTS out of range");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_err_lat
        $error("READ_LATENCY out of range");
    end
    if (STALL_SEED == 16'h0000) begin : g_err_seed
        $error("STALL_SEED must be nonzero");
    end

    logic stall;

`ifdef TB_SRAM_MP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);
    assign stall  = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    logic [IdxW-1:0] gnt_idx;
    logic            gnt_any;

    tb_rr_arb #(
        .N (NUM_PORTS)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .en_i    (!rst_i && !stall),
        .gnt_o   (gnt_o),
        .idx_o   (gnt_idx),
        .valid_o (gnt_any)
    );

    logic                  sel_we;
    logic [AW-1:0]         sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BW-1:0]         sel_be;

    assign sel_we    = we_i[gnt_idx];
    assign sel_addr  = addr_i[gnt_idx];
    assign sel_wdata = wdata_i[gnt_idx];
    assign sel_be    = be_i[gnt_idx];

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    // Storage is deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (gnt_any && sel_we) begin
            for (int unsigned b = 0; b < BW; b++) begin
                if (sel_be[b]) begin
                    mem_q[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    rsp_t                  pipe_q [READ_LATENCY];
    rsp_t                  pipe_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0] data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0] data_d [READ_LATENCY];

    always_comb begin
        pipe_d[0]         = '0;
        pipe_d[0].valid   = gnt_any;
        pipe_d[0].idx     = 3'(gnt_idx);
        pipe_d[0].is_read = !sel_we;
        data_d[0]         = (gnt_any && !sel_we) ? mem_q[sel_addr] : '0;
        for (int unsigned s = 1; s < READ_LATENCY; s++) begin
            pipe_d[s] = pipe_q[s-1];
            data_d[s] = data_q[s-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < READ_LATENCY; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < READ_LATENCY; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

    // Data stages need no reset; outputs are qualified by the valid pipeline.
    always_ff @(posedge clk_i) begin
        for (int unsigned s = 0; s < READ_LATENCY; s++) begin
            data_q[s] <= data_d[s];
        end
    end

    rsp_t rsp_out;
    assign rsp_out = pipe_q[READ_LATENCY-1];

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            rvalid_o[k] = !rst_i && rsp_out.valid && (rsp_out.idx == 3'(k));
            if (rvalid_o[k] && rsp_out.is_read) begin
                rdata_o[k] = data_q[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_tb_sram_mp.sv
// Directed self-checking bench for tb_sram_mp (3 ports, latency 2).
module tb_tb_sram_mp;

    localparam int unsigned DW = 64;
    localparam int unsigned NW = 1024;
    localparam int unsigned NP = 3;
    localparam int unsigned RL = 2;
    localparam int unsigned AW = $clog2(NW);

    logic                   clk;
    logic                   rst;
    logic [NP-1:0]          req;
    logic [NP-1:0]          we;
    logic [NP-1:0][AW-1:0]  addr;
    logic [NP-1:0][DW-1:0]  wdata;
    logic [NP-1:0][7:0]     be;
    logic [NP-1:0]          gnt;
    logic [NP-1:0]          rvalid;
    logic [NP-1:0][DW-1:0]  rdata;

    int vectors     = 0;
    int miscompares = 0;

    tb_sram_mp #(
        .DATA_WIDTH   (DW),
        .NUM_WORDS    (NW),
        .NUM_PORTS    (NP),
        .READ_LATENCY (RL),
        .STALL_SEED   (16'hACE1)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .be_i     (be),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt [NP];
`ifdef TB_SRAM_MP_STALL_EN
        logic [15:0] m;
        int exp_gnt;
        int act_gnt;
        int act_rv;
`endif
        rst   = 1'b1;
        req   = '1;
        we    = '0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        #1;
        check("rst_gnt", 64'(gnt), 64'(3'b000));
        tick();
        tick();
        check("rst_rvalid", 64'(rvalid), 64'(3'b000));
        check("rst_rdata0", rdata[0], 64'h0);
        check("rst_rdata1", rdata[1], 64'h0);
        rst = 1'b0;
        req = '0;

`ifdef TB_SRAM_MP_STALL_EN
        m = 16'hACE1;
        exp_gnt = 0;
        act_gnt = 0;
        act_rv  = 0;
        req[0]  = 1'b1;
        addr[0] = 10'd5;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (m[1:0] != 2'b00) exp_gnt++;
            if (gnt[0]) act_gnt++;
            if (rvalid[0]) act_rv++;
            tick();
            m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
        end
        req = '0;
        for (int i = 0; i < RL + 1; i++) begin
            #1;
            if (rvalid[0]) act_rv++;
            tick();
        end
        check("stall_gnt_count", 64'(act_gnt), 64'(exp_gnt));
        check("stall_rvalid_count", 64'(act_rv), 64'(act_gnt));
`else
        // Write then read on port 0.
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 10'd5;
        wdata[0] = 64'hDEADBEEF_00000539;
        be[0]    = 8'hFF;
        #1;
        check("t1_wr_gnt", 64'(gnt), 64'(3'b001));
        tick();
        we[0] = 1'b0;
        #1;
        check("t1_rd_gnt", 64'(gnt), 64'(3'b001));
        check("t1_no_early_rvalid", 64'(rvalid), 64'(3'b000));
        tick();
        req = '0;
        #1;
        check("t1_wr_ack", 64'(rvalid), 64'(3'b001));
        check("t1_wr_ack_data", rdata[0], 64'h0);
        tick();
        check("t1_rd_rvalid", 64'(rvalid), 64'(3'b001));
        check("t1_rd_data", rdata[0], 64'hDEADBEEF_00000539);
        tick();
        check("t1_idle_rvalid", 64'(rvalid), 64'(3'b000));
        check("t1_idle_rdata", rdata[0], 64'h0);

        // Byte-enable merge and a be=0 write.
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 10'd7;
        wdata[0] = 64'h0;
        be[0]    = 8'hFF;
        tick();
        wdata[0] = 64'hFFFFFFFF_FFFFFFFF;
        be[0]    = 8'h0F;
        tick();
        wdata[0] = 64'hAAAAAAAA_AAAAAAAA;
        be[0]    = 8'h00;
        #1;
        check("t2_be0_gnt", 64'(gnt), 64'(3'b001));
        tick();
        we[0] = 1'b0;
        tick();
        req = '0;
        check("t2_be0_ack", 64'(rvalid), 64'(3'b001));
        check("t2_be0_ack_data", rdata[0], 64'h0);
        tick();
        check("t2_merge_data", rdata[0], 64'h00000000_FFFFFFFF);

        // Reset while a read is in flight drops its response.
        req[1]  = 1'b1;
        we[1]   = 1'b0;
        addr[1] = 10'd5;
        #1;
        check("t3_gnt", 64'(gnt), 64'(3'b010));
        tick();
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3_dropped", 64'(rvalid), 64'(3'b000));

        // All ports reading: strict rotation from port 0.
        for (int k = 0; k < NP; k++) cnt[k] = 0;
        req  = '1;
        we   = '0;
        addr = '0;
        for (int i = 0; i < 9; i++) begin
            #1;
            check($sformatf("t4_gnt%0d", i), 64'(gnt), 64'(1) << (i % 3));
            for (int k = 0; k < NP; k++) cnt[k] += int'(rvalid[k]);
            tick();
        end
        req = '0;
        for (int i = 0; i < RL + 1; i++) begin
            for (int k = 0; k < NP; k++) cnt[k] += int'(rvalid[k]);
            tick();
        end
        for (int k = 0; k < NP; k++) begin
            check($sformatf("t4_rvalid_cnt%0d", k), 64'(cnt[k]), 64'd3);
        end

        // Write on port 0 visible to port 1 read granted next cycle.
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 10'd3;
        wdata[0] = 64'h1;
        be[0]    = 8'hFF;
        #1;
        check("t5_wr_gnt", 64'(gnt), 64'(3'b001));
        tick();
        req     = 3'b010;
        we      = '0;
        addr[1] = 10'd3;
        #1;
        check("t5_rd_gnt", 64'(gnt), 64'(3'b010));
        tick();
        req = '0;
        check("t5_wr_ack", 64'(rvalid), 64'(3'b001));
        tick();
        check("t5_rd_rvalid", 64'(rvalid), 64'(3'b010));
        check("t5_rd_data", rdata[1], 64'h1);

        // Pointer sits at 2 after the port-1 grant.
        req = 3'b101;
        #1;
        check("t6_gnt_a", 64'(gnt), 64'(3'b100));
        tick();
        check("t6_gnt_b", 64'(gnt), 64'(3'b001));
        tick();
        req = '0;
        tick();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
